// File: rtl/multicycle_control_if.sv
// Control-strobe bundle between the multicycle control FSM and its datapath.
// The master side is the control unit; the slave side is the datapath.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic [1:0] ALUop;
    logic [1:0] ALUSrcB;
    logic       MemtoReg;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       RegWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       ALUSrcA;
    logic       PCSource;

    modport master (
        input  opcode,
        output ALUop, ALUSrcB, MemtoReg, MemRead, MemWrite, IorD,
        output RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA, PCSource
    );

    modport slave (
        output opcode,
        input  ALUop, ALUSrcB, MemtoReg, MemRead, MemWrite, IorD,
        input  RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA, PCSource
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V core: Moore-decoded datapath strobes,
// a wrapping retired-instruction counter and a sticky illegal-opcode flag.
module multicycle_control #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_if.master   ctrl_io,
    output logic [3:0]             state_o,
    output logic                   illegal_op,
    output logic [COUNT_W-1:0]     instr_retired
);

    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpBeq  = 7'b1100011;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StRwb    = 4'd8,
        StBranch = 4'd9
    } state_e;

    state_e               state_q, state_d;
    logic                 illegal_q, illegal_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Next-state, flag and counter logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (ctrl_io.opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = (ctrl_io.opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StExec:   state_d = StRwb;
            StMemWb, StMemWr, StRwb, StBranch: begin
                state_d   = StFetch;
                retired_d = retired_q + COUNT_W'(1);
            end
            // Unused encodings recover to FETCH.
            default:  state_d = StFetch;
        endcase
    end

    // Moore output decode: depends on state_q only
    always_comb begin
        ctrl_io.ALUop       = 2'b00;
        ctrl_io.ALUSrcB     = 2'b00;
        ctrl_io.MemtoReg    = 1'b0;
        ctrl_io.MemRead     = 1'b0;
        ctrl_io.MemWrite    = 1'b0;
        ctrl_io.IorD        = 1'b0;
        ctrl_io.RegWrite    = 1'b0;
        ctrl_io.IRWrite     = 1'b0;
        ctrl_io.PCWrite     = 1'b0;
        ctrl_io.PCWriteCond = 1'b0;
        ctrl_io.ALUSrcA     = 1'b0;
        ctrl_io.PCSource    = 1'b0;
        case (state_q)
            StFetch: begin
                ctrl_io.MemRead = 1'b1;
                ctrl_io.IRWrite = 1'b1;
                ctrl_io.ALUSrcB = 2'b01;
                ctrl_io.PCWrite = 1'b1;
            end
            StDecode: ctrl_io.ALUSrcB = 2'b11;
            StMemAdr: begin
                ctrl_io.ALUSrcA = 1'b1;
                ctrl_io.ALUSrcB = 2'b10;
            end
            StMemRd: begin
                ctrl_io.MemRead = 1'b1;
                ctrl_io.IorD    = 1'b1;
            end
            StMemWb: begin
                ctrl_io.RegWrite = 1'b1;
                ctrl_io.MemtoReg = 1'b1;
            end
            StMemWr: begin
                ctrl_io.MemWrite = 1'b1;
                ctrl_io.IorD     = 1'b1;
            end
            StExec: begin
                ctrl_io.ALUSrcA = 1'b1;
                ctrl_io.ALUop   = 2'b10;
            end
            StRwb: ctrl_io.RegWrite = 1'b1;
            StBranch: begin
                ctrl_io.ALUSrcA     = 1'b1;
                ctrl_io.ALUop       = 2'b01;
                ctrl_io.PCWriteCond = 1'b1;
                ctrl_io.PCSource    = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o       = state_q;
    assign illegal_op    = illegal_q;
    assign instr_retired = retired_q;

    // Strobe exclusivity guards the datapath against conflicting writes.
    a_mem_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(ctrl_io.MemRead && ctrl_io.MemWrite));
    a_regwrite_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(ctrl_io.RegWrite && (ctrl_io.MemWrite || ctrl_io.IRWrite)));
    a_pcwrite_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(ctrl_io.PCWrite && ctrl_io.PCWriteCond));

endmodule
